// File: rtl/lfsr_pkg.sv
// Shared definitions for the seeded 8-bit LFSR generator and its receive-side checker.
// Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form shifting towards the MSB.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

  // Counter width for the lock/loss run lengths (1..15).
  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] run_cnt_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// Local copy of the LFSR: seeded from a received sample or stepped on its own value.
// Output is the state expected on the next valid sample.
module lfsr_predictor
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] expected
);

  logic [LFSR_W-1:0] pred_q;

  // Loading stores the successor of the seed, since the seed itself was just consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q <= '0;
    end else if (load) begin
      pred_q <= lfsr_next(seed);
    end else if (advance) begin
      pred_q <= lfsr_next(pred_q);
    end
  end

  assign expected = pred_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream: hunts, verifies, locks,
// then flywheels while counting mismatches into a saturating error counter.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clr_count,
  output logic              locked,
  output logic              error,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        state
);

  chk_state_e        state_q, state_d;
  run_cnt_t          match_q, match_d;
  run_cnt_t          miss_q, miss_d;
  logic              pred_load;
  logic              pred_adv;
  logic              count_err;
  logic              sample_hit;
  logic              sample_zero;
  logic [LFSR_W-1:0] expected;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              error_q;

  lfsr_predictor u_pred (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pred_load),
    .advance  (pred_adv),
    .seed     (data_in),
    .expected (expected)
  );

  assign sample_hit  = (data_in == expected);
  assign sample_zero = (data_in == '0);

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    miss_d    = miss_q;
    pred_load = 1'b0;
    pred_adv  = 1'b0;
    count_err = 1'b0;
    if (data_valid) begin
      unique case (state_q)
        HUNT: begin
          if (!sample_zero) begin
            pred_load = 1'b1;
            match_d   = '0;
            state_d   = VERIFY;
          end
        end
        VERIFY: begin
          if (sample_hit) begin
            pred_adv = 1'b1;
            if (match_q + run_cnt_t'(1) == run_cnt_t'(LOCK_COUNT)) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + run_cnt_t'(1);
            end
          end else begin
            match_d = '0;
            if (sample_zero) begin
              state_d = HUNT;
            end else begin
              pred_load = 1'b1;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the predictor steps on every sample, good or bad.
          pred_adv = 1'b1;
          if (sample_hit) begin
            miss_d = '0;
          end else begin
            count_err = 1'b1;
            if (miss_q + run_cnt_t'(1) == run_cnt_t'(LOSS_COUNT)) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + run_cnt_t'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      match_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  // Clear wins over a same-cycle increment; the FSM is untouched by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (clr_count) begin
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      error_q <= count_err;
      if (count_err && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign err_count = err_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: the driver pushes expected outputs per sample,
// a monitor pops and compares them one cycle after each valid/clear cycle.
module tb_lfsr_checker;

  localparam int unsigned EW  = 4;
  localparam int unsigned SAT = 15;

  typedef struct {
    logic [1:0]    st;
    logic          lk;
    logic          er;
    logic [EW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    data_in;
  logic          data_valid;
  logic          clr_count;
  logic          locked;
  logic          error;
  logic [EW-1:0] err_count;
  logic [1:0]    state;

  int checks;
  int failures;
  exp_t sb_q[$];

  // reference model state
  int         m_state;
  logic [7:0] m_pred;
  int         m_match;
  int         m_miss;
  logic       m_err;
  int         m_cnt;
  logic [7:0] g;

  lfsr_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (4),
    .ERR_W      (EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clr_count  (clr_count),
    .locked     (locked),
    .error      (error),
    .err_count  (err_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] tnext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pred = 8'h00; m_match = 0; m_miss = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic mis;
    m_err = 1'b0;
    if (v) begin
      case (m_state)
        0: if (d != 8'h00) begin m_pred = tnext(d); m_match = 0; m_state = 1; end
        1: begin
          if (d == m_pred) begin
            m_pred = tnext(m_pred);
            m_match++;
            if (m_match == 4) begin m_state = 2; m_match = 0; m_miss = 0; end
          end else if (d != 8'h00) begin
            m_pred = tnext(d); m_match = 0;
          end else begin
            m_state = 0; m_match = 0;
          end
        end
        default: begin
          mis = (d != m_pred);
          m_pred = tnext(m_pred);
          if (mis) begin
            m_err = 1'b1;
            if (m_cnt < SAT) m_cnt++;
            m_miss++;
            if (m_miss == 4) begin m_state = 0; m_miss = 0; end
          end else begin
            m_miss = 0;
          end
        end
      endcase
    end
    if (c) begin m_err = 1'b0; m_cnt = 0; end
  endtask

  task automatic put(input logic v, input logic [7:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    clr_count  = c;
    model_step(v, d, c);
    if (v || c) begin
      e.st  = 2'(m_state);
      e.lk  = (m_state == 2);
      e.er  = m_err;
      e.cnt = EW'(m_cnt);
      sb_q.push_back(e);
    end
  endtask

  task automatic good();
    put(1'b1, g, 1'b0);
    g = tnext(g);
  endtask

  task automatic bad();
    put(1'b1, g ^ 8'h5A, 1'b0);
    g = tnext(g);
  endtask

  task automatic idle();
    put(1'b0, 8'h00, 1'b0);
  endtask

  // monitor: compares the outputs that follow every valid or clear cycle
  initial begin
    logic sv;
    exp_t e;
    forever begin
      @(posedge clk);
      sv = (data_valid | clr_count) & rst_n;
      @(negedge clk);
      if (sv) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_state", int'(state), int'(e.st));
          chk("sb_locked", int'(locked), int'(e.lk));
          chk("sb_error", int'(error), int'(e.er));
          chk("sb_err_count", int'(err_count), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; clr_count = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_err_count", int'(err_count), 0);
    rst_n = 1'b1;

    // acquire on 01 02 04 08 11, flywheel 23, corrupt 47 -> 46, then 8E matches
    put(1'b1, 8'h01, 1'b0);
    put(1'b1, 8'h02, 1'b0);
    put(1'b1, 8'h04, 1'b0);
    put(1'b1, 8'h08, 1'b0);
    put(1'b1, 8'h11, 1'b0);
    put(1'b1, 8'h23, 1'b0);
    put(1'b1, 8'h46, 1'b0);
    put(1'b1, 8'h8E, 1'b0);
    idle();
    chk("dir_locked_after_single_err", int'(locked), 1);
    chk("dir_err_count_1", int'(err_count), 1);
    chk("dir_error_cleared", int'(error), 0);

    // four consecutive bad samples drop lock; 5th count overall
    g = 8'h1C;
    repeat (4) bad();
    idle();
    chk("dir_loss_state", int'(state), 0);
    chk("dir_loss_locked", int'(locked), 0);
    chk("dir_loss_err_count", int'(err_count), 5);
    put(1'b1, 8'h01, 1'b0);
    idle();
    chk("dir_restart_verify", int'(state), 1);

    // clear without a sample, then zeros in HUNT and a VERIFY reseed
    put(1'b0, 8'h00, 1'b1);
    put(1'b1, 8'h00, 1'b0);
    put(1'b1, 8'h00, 1'b0);
    put(1'b1, 8'h00, 1'b0);
    idle();
    chk("dir_zero_hunt", int'(state), 0);
    put(1'b1, 8'h01, 1'b0);
    put(1'b1, 8'h02, 1'b0);
    put(1'b1, 8'h05, 1'b0);
    put(1'b1, 8'h0A, 1'b0);
    put(1'b1, 8'h15, 1'b0);
    idle();
    chk("dir_reseed_verify", int'(state), 1);
    put(1'b1, 8'h00, 1'b0);

    // gapped correct stream: one sample every third cycle
    g = 8'h01;
    repeat (7) begin
      good();
      idle();
      idle();
    end
    chk("dir_gap_locked", int'(locked), 1);
    chk("dir_gap_no_errors", int'(err_count), 0);

    // 20 isolated errors saturate the 4-bit counter without losing lock
    repeat (20) begin
      bad();
      good();
    end
    idle();
    chk("dir_sat_err_count", int'(err_count), 15);
    chk("dir_sat_locked", int'(locked), 1);

    // clear in the same cycle as an error increment
    put(1'b1, g ^ 8'h5A, 1'b1);
    g = tnext(g);
    idle();
    chk("dir_clr_err_count", int'(err_count), 0);
    chk("dir_clr_error", int'(error), 0);
    chk("dir_clr_locked", int'(locked), 1);

    // asynchronous reset mid-stream
    bad();
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_error", int'(error), 0);
    chk("async_rst_err_count", int'(err_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    put(1'b1, 8'h01, 1'b0);
    put(1'b1, 8'h02, 1'b0);
    idle();
    idle();
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
